// File: rtl/dcache_wb2.sv
// Two-way set-associative write-back/write-allocate data cache with a word-serial memory port.
// Optional LRU replacement via DCACHE_LRU_EN; FIFO replacement otherwise.
module dcache_wb2 #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_req,
   input  logic [3:0]  wr_req,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
   localparam int SETS       = 1 << SET_ADDR_LEN;
   localparam int SET_LSB    = 2 + LINE_ADDR_LEN;
   localparam int TAG_LSB    = SET_LSB + SET_ADDR_LEN;
   localparam int TAG_LEN    = 32 - TAG_LSB;
   localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = LINE_ADDR_LEN'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, WBACK, FILL, DONE} state_t;

   state_t state;

   logic [31:0]        data_q  [0:1][SETS][LINE_WORDS];
   logic [TAG_LEN-1:0] tag_q   [0:1][SETS];
   logic [1:0]         valid_q [SETS];
   logic [1:0]         dirty_q [SETS];
   logic [SETS-1:0]    repl_q;

   logic                     vic_way;
   logic [SET_ADDR_LEN-1:0]  lat_set;
   logic [TAG_LEN-1:0]       lat_tag;
   logic [TAG_LEN-1:0]       old_tag;
   logic [LINE_ADDR_LEN-1:0] beat;
   logic [LINE_ADDR_LEN-1:0] beat_nxt;

   logic [TAG_LEN-1:0]       tag_in;
   logic [SET_ADDR_LEN-1:0]  set_in;
   logic [LINE_ADDR_LEN-1:0] word_in;
   logic                     access, is_wr;
   logic                     hit0, hit1, hit, hit_way, vic_c, serve;
   logic [31:0]              merged;
   logic                     unused_addr;

   assign tag_in      = addr[31:TAG_LSB];
   assign set_in      = addr[TAG_LSB-1:SET_LSB];
   assign word_in     = addr[SET_LSB-1:2];
   assign access      = rd_req || (|wr_req);
   assign is_wr       = |wr_req;
   assign beat_nxt    = beat + LINE_ADDR_LEN'(1);
   assign unused_addr = ^addr[1:0];

   always_comb begin
      hit0    = valid_q[set_in][0] && (tag_q[0][set_in] == tag_in);
      hit1    = valid_q[set_in][1] && (tag_q[1][set_in] == tag_in);
      hit     = hit0 || hit1;
      hit_way = !hit0;
      rd_data = data_q[hit_way][set_in][word_in];
      for (int b = 0; b < 4; b++)
         merged[8*b +: 8] = wr_req[b] ? wr_data[8*b +: 8] : rd_data[8*b +: 8];
      // Prefer an invalid way; fall back to the replacement pointer.
      if (!valid_q[set_in][0])      vic_c = 1'b0;
      else if (!valid_q[set_in][1]) vic_c = 1'b1;
      else                          vic_c = repl_q[set_in];
      serve = ((state == IDLE) || (state == DONE)) && access && hit;
      miss  = (state == WBACK) || (state == FILL) ||
              (((state == IDLE) || (state == DONE)) && access && !hit);
   end

   // Data and tag storage carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (serve && is_wr)
         data_q[hit_way][set_in][word_in] <= merged;
      if ((state == FILL) && mem_req && mem_ack) begin
         data_q[vic_way][lat_set][beat] <= mem_rdata;
         if (beat == LAST_BEAT)
            tag_q[vic_way][lat_set] <= lat_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= 2'b00;
            dirty_q[s] <= 2'b00;
         end
         repl_q    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         vic_way   <= 1'b0;
         lat_set   <= '0;
         lat_tag   <= '0;
         old_tag   <= '0;
         beat      <= '0;
      end else begin
         if (serve) begin
            if (is_wr) dirty_q[set_in][hit_way] <= 1'b1;
`ifdef DCACHE_LRU_EN
            repl_q[set_in] <= !hit_way;
`endif
         end
         case (state)
            IDLE: begin
               if (serve) hit_cnt <= hit_cnt + 32'd1;
               if (access && !hit) begin
                  miss_cnt <= miss_cnt + 32'd1;
                  vic_way  <= vic_c;
                  lat_set  <= set_in;
                  lat_tag  <= tag_in;
                  old_tag  <= tag_q[vic_c][set_in];
                  beat     <= '0;
                  state    <= (valid_q[set_in][vic_c] && dirty_q[set_in][vic_c]) ? WBACK : FILL;
               end
            end
            WBACK: begin
               if (!mem_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {old_tag, lat_set, beat, 2'b00};
                  mem_wdata <= data_q[vic_way][lat_set][beat];
               end else if (mem_ack) begin
                  if (beat == LAST_BEAT) begin
                     // Roll straight into the first fill beat without dropping mem_req.
                     beat     <= '0;
                     mem_we   <= 1'b0;
                     mem_addr <= {lat_tag, lat_set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
                     state    <= FILL;
                  end else begin
                     beat      <= beat_nxt;
                     mem_addr  <= {old_tag, lat_set, beat_nxt, 2'b00};
                     mem_wdata <= data_q[vic_way][lat_set][beat_nxt];
                  end
               end
            end
            FILL: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {lat_tag, lat_set, beat, 2'b00};
               end else if (mem_ack) begin
                  if (beat == LAST_BEAT) begin
                     valid_q[lat_set][vic_way] <= 1'b1;
                     dirty_q[lat_set][vic_way] <= 1'b0;
`ifndef DCACHE_LRU_EN
                     if (vic_way == repl_q[lat_set])
                        repl_q[lat_set] <= !repl_q[lat_set];
`endif
                     mem_req <= 1'b0;
                     state   <= DONE;
                  end else begin
                     beat     <= beat_nxt;
                     mem_addr <= {lat_tag, lat_set, beat_nxt, 2'b00};
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
